// File: rtl/dds_param_bank.sv
// ---------------------------------------------------------------------------
// dds_param_bank
//
// Per-channel parameter bank for the DDS core. Accepts decoded commands
// {channel, adder, amplitude} from the UART frame parser over a valid/ready
// handshake, stores each in a per-channel shadow register, and copies the
// shadow into the active register that feeds the phase accumulator and the
// amplitude scaler.
//
// Optional feature (compile-time macro DDS_PARAM_SYNC_APPLY_EN):
//   defined   - a pending shadow value is applied only on that channel's
//               phase_wrap pulse, so frequency/amplitude changes land at a
//               phase wrap (glitch-free).
//   undefined - a pending shadow value is applied on the next edge after it
//               was written; phase_wrap is ignored.
//
// Ports:
//   clk            system clock
//   rst            synchronous active-high reset
//   cmd_valid      command present
//   cmd_ready      bank can accept a command (depends on FSM state only)
//   cmd_channel    target channel, 8'hFF broadcasts to every channel
//   cmd_adder      phase increment
//   cmd_amplitude  amplitude
//   phase_wrap     per-channel accumulator overflow pulse
//   ch_adder       active adders, channel k at [k*PHASE_W +: PHASE_W]
//   ch_amplitude   active amplitudes, channel k at [k*AMP_W +: AMP_W]
//   ch_update      1-cycle pulse: channel k active registers changed
//   pending        channel k shadow awaits apply
//   cmd_error      1-cycle pulse: invalid channel index, command dropped
// ---------------------------------------------------------------------------
module dds_param_bank #(
  parameter int                NUM_CH      = 4,
  parameter int                PHASE_W     = 32,
  parameter int                AMP_W       = 32,
  parameter logic [PHASE_W-1:0] RESET_ADDER = PHASE_W'(1000000),
  parameter logic [AMP_W-1:0]   RESET_AMP   = AMP_W'(1000000)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [7:0]                cmd_channel,
  input  logic [PHASE_W-1:0]        cmd_adder,
  input  logic [AMP_W-1:0]          cmd_amplitude,
  input  logic [NUM_CH-1:0]         phase_wrap,
  output logic [NUM_CH*PHASE_W-1:0] ch_adder,
  output logic [NUM_CH*AMP_W-1:0]   ch_amplitude,
  output logic [NUM_CH-1:0]         ch_update,
  output logic [NUM_CH-1:0]         pending,
  output logic                      cmd_error
);

  typedef enum logic {IDLE, CHECK} state_t;

  state_t state, state_next;
  logic   capture_en;

  // Captured command, consumed in CHECK.
  logic [7:0]         cap_channel;
  logic [PHASE_W-1:0] cap_adder;
  logic [AMP_W-1:0]   cap_amp;

  // Per-channel storage.
  logic [PHASE_W-1:0] shadow_adder [NUM_CH];
  logic [AMP_W-1:0]   shadow_amp   [NUM_CH];
  logic [PHASE_W-1:0] active_adder [NUM_CH];
  logic [AMP_W-1:0]   active_amp   [NUM_CH];

  logic [NUM_CH-1:0] wr_hit;     // channel written by CHECK this edge
  logic              bad_ch;     // CHECK holds an out-of-range index
  logic [NUM_CH-1:0] apply_en;   // per-channel apply qualifier
  logic [NUM_CH-1:0] apply_fire; // pending value moves to active this edge

  // ---------------------------------------------------------------- FSM
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking assignments here would create ordering races.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every output of this block gets a default first, otherwise a path
  // that skips an assignment infers a latch.
  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    capture_en = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          capture_en = 1'b1;
          state_next = CHECK;
        end
      end
      CHECK:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: the capture registers are deliberately left without reset; they
  // are only observed in CHECK, which always follows a fresh capture, so a
  // reset would cost fan-out for nothing. Architectural state (shadow,
  // active, pending) does reset because its value is visible after reset.
  always_ff @(posedge clk) begin
    if (capture_en) begin
      cap_channel <= cmd_channel;
      cap_adder   <= cmd_adder;
      cap_amp     <= cmd_amplitude;
    end
  end

  // ------------------------------------------------------ write decode
  always_comb begin
    wr_hit = '0;
    bad_ch = 1'b0;
    if (state == CHECK) begin
      for (int k = 0; k < NUM_CH; k++)
        wr_hit[k] = (cap_channel == 8'hFF) || (cap_channel == 8'(k));
      bad_ch = (cap_channel != 8'hFF) && (int'(cap_channel) >= NUM_CH);
    end
  end

  // ------------------------------------------------------ apply qualifier
`ifdef DDS_PARAM_SYNC_APPLY_EN
  assign apply_en = phase_wrap;
`else
  assign apply_en = '1;
  logic unused_phase_wrap;
  assign unused_phase_wrap = ^phase_wrap;
`endif

  assign apply_fire = pending & apply_en;

  // ------------------------------------------------------ per-channel regs
  // Apply reads the pre-edge shadow, so a CHECK write colliding with an
  // apply leaves active = old shadow, shadow = new value and pending set.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_CH; k++) begin
        shadow_adder[k] <= RESET_ADDER;
        shadow_amp[k]   <= RESET_AMP;
        active_adder[k] <= RESET_ADDER;
        active_amp[k]   <= RESET_AMP;
      end
      pending   <= '0;
      ch_update <= '0;
      cmd_error <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (apply_fire[k]) begin
          active_adder[k] <= shadow_adder[k];
          active_amp[k]   <= shadow_amp[k];
        end
        if (wr_hit[k]) begin
          shadow_adder[k] <= cap_adder;
          shadow_amp[k]   <= cap_amp;
          pending[k]      <= 1'b1;
        end else if (apply_fire[k]) begin
          pending[k] <= 1'b0;
        end
      end
      ch_update <= apply_fire;
      cmd_error <= bad_ch;
    end
  end

  // ------------------------------------------------------ output packing
  for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
    assign ch_adder[g*PHASE_W +: PHASE_W] = active_adder[g];
    assign ch_amplitude[g*AMP_W +: AMP_W] = active_amp[g];
  end

endmodule
